// File: rtl/pcie_pkg.sv
// Shared definitions for the transaction datapath: arbiter state encoding,
// data-word field positions and default widths.
package pcie_pkg;

  localparam int unsigned DEF_WGT_W = 3;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned VC_BIT    = 4;
  localparam int unsigned DEST_BIT  = 5;

  typedef enum logic {
    SERVE_VC0 = 1'b0,
    SERVE_VC1 = 1'b1
  } wrr_state_e;

endpackage

// File: rtl/vc_pop_scheduler_wrr_credit.sv
// Weighted round-robin between VC0 and VC1: turn state plus consecutive-grant
// credit; flags a pop request for the VC owning the turn.
module wrr_credit
  import pcie_pkg::*;
#(
  parameter int unsigned WGT_W = DEF_WGT_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable_i,
  input  logic [WGT_W-1:0] weight_VC0_i,
  input  logic [WGT_W-1:0] weight_VC1_i,
  input  logic             elig_VC0_i,
  input  logic             elig_VC1_i,
  input  logic             dest_ok_i,
  output logic             grant_o,
  output logic             pop_req_o,
  output logic             switch_o
);

  wrr_state_e       state_q, state_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic [WGT_W:0]   cur_w, eff_w, credit_inc;
  logic             elig_cur, elig_oth;

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    pop_req_o  = 1'b0;
    switch_o   = 1'b0;
    cur_w      = (state_q == SERVE_VC0) ? {1'b0, weight_VC0_i} : {1'b0, weight_VC1_i};
    eff_w      = (cur_w == '0) ? (WGT_W+1)'(1) : cur_w;
    elig_cur   = (state_q == SERVE_VC0) ? elig_VC0_i : elig_VC1_i;
    elig_oth   = (state_q == SERVE_VC0) ? elig_VC1_i : elig_VC0_i;
    credit_inc = {1'b0, credit_q} + (WGT_W+1)'(1);
    // Back-pressure freezes the turn entirely, including work-conserving hand-over.
    if (enable_i && dest_ok_i) begin
      if (elig_cur) begin
        pop_req_o = 1'b1;
        if (credit_inc >= eff_w) switch_o = 1'b1;
        else                     credit_d = credit_inc[WGT_W-1:0];
      end else if (elig_oth) begin
        switch_o = 1'b1;
      end
    end
    if (switch_o) begin
      state_d  = (state_q == SERVE_VC0) ? SERVE_VC1 : SERVE_VC0;
      credit_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= SERVE_VC0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  assign grant_o = state_q;

endmodule

// File: rtl/vc_pop_scheduler.sv
// Pop sequencer for the main FIFO and the two VC FIFOs: MF gating by target
// Pausa, WRR arbitration between VCs, registered pops and per-VC grant counters.
module vc_pop_scheduler
  import pcie_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned WGT_W = DEF_WGT_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [WGT_W-1:0] weight_VC0,
  input  logic [WGT_W-1:0] weight_VC1,
  input  logic             Fifo_Empty_MF,
  input  logic             Almost_Empty_MF,
  input  logic             head_vc_MF,
  input  logic             Fifo_Empty_VC0,
  input  logic             Almost_Empty_VC0,
  input  logic             Pausa_VC0,
  input  logic             Fifo_Empty_VC1,
  input  logic             Almost_Empty_VC1,
  input  logic             Pausa_VC1,
  input  logic             Pausa_D0,
  input  logic             Pausa_D1,
  output logic             pop_MF,
  output logic             pop_VC0,
  output logic             pop_VC1,
  output logic             grant_vc,
  output logic [CNT_W-1:0] grant_cnt_VC0,
  output logic [CNT_W-1:0] grant_cnt_VC1
);

  logic             pop_MF_q, pop_MF_d;
  logic             pop_VC0_q, pop_VC0_d;
  logic             pop_VC1_q, pop_VC1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             pausa_target, mf_ok, elig0, elig1, dest_ok;
  logic             grant, pop_req, wrr_switch;

  // Empty lags a registered pop by one cycle, so an almost-empty FIFO is
  // never popped on consecutive cycles.
  assign pausa_target = head_vc_MF ? Pausa_VC1 : Pausa_VC0;
  assign mf_ok   = !Fifo_Empty_MF && !pausa_target && !(pop_MF_q && Almost_Empty_MF);
  assign elig0   = !Fifo_Empty_VC0 && !(pop_VC0_q && Almost_Empty_VC0);
  assign elig1   = !Fifo_Empty_VC1 && !(pop_VC1_q && Almost_Empty_VC1);
  assign dest_ok = !Pausa_D0 && !Pausa_D1;

  wrr_credit #(.WGT_W(WGT_W)) u_wrr (
    .clk          (clk),
    .reset_L      (reset_L),
    .enable_i     (enable),
    .weight_VC0_i (weight_VC0),
    .weight_VC1_i (weight_VC1),
    .elig_VC0_i   (elig0),
    .elig_VC1_i   (elig1),
    .dest_ok_i    (dest_ok),
    .grant_o      (grant),
    .pop_req_o    (pop_req),
    .switch_o     (wrr_switch)
  );

  always_comb begin
    pop_MF_d  = enable && mf_ok;
    pop_VC0_d = pop_req && !grant;
    pop_VC1_d = pop_req && grant && !wrr_switch ? 1'b1 : (pop_req && grant);
    cnt0_d    = cnt0_q + CNT_W'(pop_VC0_d);
    cnt1_d    = cnt1_q + CNT_W'(pop_VC1_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      pop_MF_q  <= 1'b0;
      pop_VC0_q <= 1'b0;
      pop_VC1_q <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      pop_MF_q  <= pop_MF_d;
      pop_VC0_q <= pop_VC0_d;
      pop_VC1_q <= pop_VC1_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign pop_MF        = pop_MF_q;
  assign pop_VC0       = pop_VC0_q;
  assign pop_VC1       = pop_VC1_q;
  assign grant_vc      = grant;
  assign grant_cnt_VC0 = cnt0_q;
  assign grant_cnt_VC1 = cnt1_q;

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Directed bench for vc_pop_scheduler: a vector table for arbitration and
// gating, plus FIFO-model sequences for work-conserving, MF single-entry and wrap cases.
module tb_vc_pop_scheduler;

  logic       clk = 1'b0;
  logic       reset_L, enable;
  logic [2:0] weight_VC0, weight_VC1;
  logic       Fifo_Empty_MF, Almost_Empty_MF, head_vc_MF;
  logic       Fifo_Empty_VC0, Almost_Empty_VC0, Pausa_VC0;
  logic       Fifo_Empty_VC1, Almost_Empty_VC1, Pausa_VC1;
  logic       Pausa_D0, Pausa_D1;
  logic       pop_MF, pop_VC0, pop_VC1, grant_vc;
  logic [7:0] grant_cnt_VC0, grant_cnt_VC1;

  int total = 0;
  int bad   = 0;
  int n0, n1, nMF;

  always #5 clk = ~clk;

  vc_pop_scheduler #(.CNT_W(8), .WGT_W(3)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .weight_VC0(weight_VC0), .weight_VC1(weight_VC1),
    .Fifo_Empty_MF(Fifo_Empty_MF), .Almost_Empty_MF(Almost_Empty_MF), .head_vc_MF(head_vc_MF),
    .Fifo_Empty_VC0(Fifo_Empty_VC0), .Almost_Empty_VC0(Almost_Empty_VC0), .Pausa_VC0(Pausa_VC0),
    .Fifo_Empty_VC1(Fifo_Empty_VC1), .Almost_Empty_VC1(Almost_Empty_VC1), .Pausa_VC1(Pausa_VC1),
    .Pausa_D0(Pausa_D0), .Pausa_D1(Pausa_D1),
    .pop_MF(pop_MF), .pop_VC0(pop_VC0), .pop_VC1(pop_VC1), .grant_vc(grant_vc),
    .grant_cnt_VC0(grant_cnt_VC0), .grant_cnt_VC1(grant_cnt_VC1)
  );

  typedef struct {
    logic       rst_n, en, e0, e1, ae0, ae1, pd0, pd1;
    logic [2:0] w0, w1;
    logic       p0, p1, g;
    logic [7:0] c0, c1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, en, e0, e1, ae0, ae1, pd0, pd1,
                              input int w0, w1, input logic p0, p1, g, input int c0, c1);
    vec_t v;
    v.rst_n = r;  v.en = en;  v.e0 = e0;  v.e1 = e1;
    v.ae0 = ae0;  v.ae1 = ae1; v.pd0 = pd0; v.pd1 = pd1;
    v.w0 = 3'(w0); v.w1 = 3'(w1);
    v.p0 = p0; v.p1 = p1; v.g = g;
    v.c0 = 8'(c0); v.c1 = 8'(c1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags();
    Fifo_Empty_VC0   = (n0 == 0);
    Almost_Empty_VC0 = (n0 <= 1);
    Fifo_Empty_VC1   = (n1 == 0);
    Almost_Empty_VC1 = (n1 <= 1);
    Fifo_Empty_MF    = (nMF == 0);
    Almost_Empty_MF  = (nMF <= 1);
  endtask

  // FIFOs consume the pop strobes visible before the edge.
  task automatic model_tick();
    logic pv0, pv1, pmf;
    pv0 = pop_VC0; pv1 = pop_VC1; pmf = pop_MF;
    @(posedge clk);
    #1;
    if (pv0) begin if (n0 == 0) chk("vc0_underflow", 1, 0); else n0--; end
    if (pv1) begin if (n1 == 0) chk("vc1_underflow", 1, 0); else n1--; end
    if (pmf) begin if (nMF == 0) chk("mf_underflow", 1, 0); else nMF--; end
    set_flags();
  endtask

  task automatic model_reset();
    reset_L = 1'b0;
    set_flags();
    tick();
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0cnt, p1cnt, mfcnt, idle, maxidle, both;
    bit seen, done;

    reset_L = 1'b0; enable = 1'b1; weight_VC0 = 3'd3; weight_VC1 = 3'd1;
    Fifo_Empty_MF = 1'b1; Almost_Empty_MF = 1'b1; head_vc_MF = 1'b0;
    Pausa_VC0 = 1'b0; Pausa_VC1 = 1'b0;
    Fifo_Empty_VC0 = 1'b0; Almost_Empty_VC0 = 1'b0;
    Fifo_Empty_VC1 = 1'b0; Almost_Empty_VC1 = 1'b0;
    Pausa_D0 = 1'b0; Pausa_D1 = 1'b0;

    //              r  en e0 e1 a0 a1 d0 d1 w0 w1  p0 p1 g  c0 c1
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 1,  0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 1,  0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 0, 2, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 1, 3, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  0, 1, 0, 3, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 0, 4, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 1,  0, 0, 0, 4, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 1,  0, 0, 0, 4, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 1,  0, 0, 0, 4, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 1,  0, 0, 0, 4, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 0, 5, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 1, 6, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  0, 1, 0, 6, 2));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 1,  0, 0, 0, 6, 2));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 1,  0, 0, 0, 6, 2));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 0, 7, 2));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 8, 2));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 8, 3));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 9, 3));
    vt.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 9, 4));
    vt.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 9, 4));
    vt.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 9, 4));
    vt.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 9, 5));
    vt.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 9, 5));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 1,  0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 3, 1,  1, 0, 0, 1, 0));

    foreach (vt[i]) begin
      reset_L = vt[i].rst_n; enable = vt[i].en;
      Fifo_Empty_VC0 = vt[i].e0; Fifo_Empty_VC1 = vt[i].e1;
      Almost_Empty_VC0 = vt[i].ae0; Almost_Empty_VC1 = vt[i].ae1;
      Pausa_D0 = vt[i].pd0; Pausa_D1 = vt[i].pd1;
      weight_VC0 = vt[i].w0; weight_VC1 = vt[i].w1;
      tick();
      chk($sformatf("row%0d_pop_VC0", i), 32'(pop_VC0), 32'(vt[i].p0));
      chk($sformatf("row%0d_pop_VC1", i), 32'(pop_VC1), 32'(vt[i].p1));
      chk($sformatf("row%0d_grant_vc", i), 32'(grant_vc), 32'(vt[i].g));
      chk($sformatf("row%0d_cnt_VC0", i), 32'(grant_cnt_VC0), 32'(vt[i].c0));
      chk($sformatf("row%0d_cnt_VC1", i), 32'(grant_cnt_VC1), 32'(vt[i].c1));
      chk($sformatf("row%0d_pop_MF", i), 32'(pop_MF), 32'd0);
    end

    // Work-conserving: VC0 empty, VC1 holds 5 words, weight 2.
    enable = 1'b1; Pausa_D0 = 1'b0; Pausa_D1 = 1'b0;
    weight_VC0 = 3'd1; weight_VC1 = 3'd2;
    n0 = 0; n1 = 5; nMF = 0;
    model_reset();
    p0cnt = 0; p1cnt = 0; idle = 0; maxidle = 0; both = 0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      model_tick();
      if (pop_VC0) p0cnt++;
      if (pop_VC0 && pop_VC1) both++;
      if (pop_VC1) begin
        p1cnt++;
        if (seen && idle > maxidle) maxidle = idle;
        idle = 0; seen = 1;
      end else if (seen) begin
        idle++;
      end
    end
    chk("wc_vc1_pops", 32'(p1cnt), 32'd5);
    chk("wc_vc0_pops", 32'(p0cnt), 32'd0);
    chk("wc_cnt_VC1", 32'(grant_cnt_VC1), 32'd5);
    chk("wc_max_idle_le1", 32'(maxidle <= 1), 32'd1);
    chk("wc_both_high", 32'(both), 32'd0);
    chk("wc_vc1_drained", 32'(n1), 32'd0);

    // Single-entry MF targeting VC1; Pausa_VC0 must not matter.
    n0 = 0; n1 = 0; nMF = 0;
    head_vc_MF = 1'b1; Pausa_VC0 = 1'b1; Pausa_VC1 = 1'b0;
    model_reset();
    nMF = 1; set_flags();
    mfcnt = 0;
    for (int c = 0; c < 10; c++) begin
      model_tick();
      if (pop_MF) mfcnt++;
    end
    chk("mf_single_pulse", 32'(mfcnt), 32'd1);
    chk("mf_drained", 32'(nMF), 32'd0);
    Pausa_VC1 = 1'b1; nMF = 1; set_flags();
    mfcnt = 0;
    for (int c = 0; c < 6; c++) begin
      model_tick();
      if (pop_MF) mfcnt++;
    end
    chk("mf_blocked_by_pausa_vc1", 32'(mfcnt), 32'd0);
    Pausa_VC1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      model_tick();
      if (pop_MF) mfcnt++;
    end
    chk("mf_after_pausa_release", 32'(mfcnt), 32'd1);
    Pausa_VC0 = 1'b0; head_vc_MF = 1'b0;

    // Counter wrap after 256 VC0 pops, then enable drop freezes everything.
    weight_VC0 = 3'd7; weight_VC1 = 3'd1;
    n0 = 100000; n1 = 0; nMF = 0;
    model_reset();
    p0cnt = 0; done = 0;
    for (int c = 0; c < 1200 && !done; c++) begin
      model_tick();
      if (pop_VC0) begin
        p0cnt++;
        if (p0cnt == 255) chk("wrap_cnt_at_255", 32'(grant_cnt_VC0), 32'd255);
        if (p0cnt == 256) begin
          chk("wrap_cnt_at_256", 32'(grant_cnt_VC0), 32'd0);
          done = 1;
        end
      end
    end
    chk("wrap_reached_in_budget", 32'(done), 32'd1);
    chk("wrap_cnt_VC1", 32'(grant_cnt_VC1), 32'd0);
    enable = 1'b0;
    model_tick();
    chk("en0_pop_VC0", 32'(pop_VC0), 32'd0);
    chk("en0_pop_VC1", 32'(pop_VC1), 32'd0);
    chk("en0_cnt_frozen", 32'(grant_cnt_VC0), 32'd0);
    model_tick();
    chk("en0_cnt_frozen2", 32'(grant_cnt_VC0), 32'd0);
    enable = 1'b1;
    model_tick();
    chk("reenable_cnt", 32'(grant_cnt_VC0), 32'(pop_VC0 ? 1 : 0));
    chk("reenable_any_pop", 32'(pop_VC0 | pop_VC1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_pop_scheduler.md
# vc_pop_scheduler

- Sequences every read in the transaction datapath.
- Generates the main-FIFO pop (MF → demux → VC0/VC1) and the VC0/VC1 pops (→ mux → D0/D1 demux).
- Uses a weighted round-robin between the two virtual channels, gated by downstream back-pressure (Pausa) and by empty/almost-empty flags.
- Sits between the FIFO status outputs and the FIFO pop inputs, and replaces ad-hoc pop logic at the top level. Enabled by the control FSM's active state.

## Interface
Parameters:
- CNT_W, 8, width of per-VC grant counters
- WGT_W, 3, width of VC weight inputs

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_L  in  1  synchronous, active-low reset
- enable  in  1  scheduling allowed (control FSM active_out)
- weight_VC0, weight_VC1  in  WGT_W  consecutive grants per VC turn; 0 treated as 1
- Fifo_Empty_MF, Almost_Empty_MF  in  1  main FIFO status
- head_vc_MF  in  1  bit 4 of main FIFO head word: 0→VC0, 1→VC1
- Fifo_Empty_VC0, Almost_Empty_VC0, Pausa_VC0  in  1  VC0 FIFO status
- Fifo_Empty_VC1, Almost_Empty_VC1, Pausa_VC1  in  1  VC1 FIFO status
- Pausa_D0, Pausa_D1  in  1  destination FIFO back-pressure
- pop_MF, pop_VC0, pop_VC1  out  1  registered pop strobes
- grant_vc  out  1  VC currently owning the turn (0/1)
- grant_cnt_VC0, grant_cnt_VC1  out  CNT_W  wrapping count of pops issued per VC

## Operation
- **Reset** (reset_L=0 at edge): all pops 0, grant_vc=0, credit=0, both counters 0, state SERVE_VC0.
- **enable=0**: all pops 0 next cycle. State, credit and counters are held.

MF pop (independent of VC arbitration):
- `mf_ok = !Fifo_Empty_MF && !Pausa_target && !(pop_MF && Almost_Empty_MF)`.
- `Pausa_target` = Pausa_VC0 when head_vc_MF=0, else Pausa_VC1.

VC eligibility:
- `elig_x = !Fifo_Empty_VCx && !(pop_VCx && Almost_Empty_VCx)`.
- `dest_ok = !Pausa_D0 && !Pausa_D1`. The destination is unknown before the pop, so both destinations must be open.

State machine (SERVE_VC0, SERVE_VC1) with a WGT_W-bit credit counter:
- In SERVE_VCx with elig_x && dest_ok: pop_VCx=1 and credit+1.
- Switch to the other state, clearing credit, when any of these holds:
  - credit+1 reaches the effective weight after a grant;
  - elig_x=0 and elig_other=1 (work-conserving switch, no pop that cycle).
- When both are ineligible or dest_ok=0: no pop; state and credit held.
- At most one of pop_VC0/pop_VC1 is high in any cycle.

Counters and grant_vc:
- grant_cnt_VCx increments on each pop_VCx and wraps 2^CNT_W−1 → 0.
- grant_vc equals the current state (0 = SERVE_VC0).

## Timing
- All outputs are registered. Flags sampled at edge N produce pops valid during cycle N+1, consumed by the FIFOs at edge N+1.
- **Almost-empty guard**: when a pop was issued last cycle, the Empty flag lags. A FIFO with Almost_Empty=1 therefore gets no back-to-back pop, so a 1-entry FIFO is never popped twice.
- **Pausa thresholds**: set with ≥2 entries of margin to cover the registered-pop and demux/mux pipeline latency (2 cycles MF→VC, 2 cycles VC→Dx).
- **Simultaneous events**:
  - weight reached and other VC ineligible: still switch. The next cycle's work-conserving rule returns to the original VC.
  - Weight inputs change mid-turn: take effect at the next comparison.
- **reset_L low mid-burst**: pops drop the following cycle; no partial state is retained.
- MF and VC pops may be high in the same cycle.

## Structure
- Shared package `pcie_pkg`:
  - state encoding: SERVE_VC0=1'b0, SERVE_VC1=1'b1;
  - data-word field indices: VC bit=4, DEST bit=5;
  - default WGT_W, CNT_W.
- Natural sub-module: `wrr_credit`, holding the weighted-round-robin state/credit logic and exposing grant and switch.
- MF gating and the counters stay in the top module.

## Test plan
- **Reset:** reset_L=0 for 2 cycles with all FIFOs non-empty → all pops 0, grant_vc=0, counters 0; first pop_VC0 in the 2nd cycle after release with enable=1.
- **Weights:** weight_VC0=3, weight_VC1=1, both VCs deep, no Pausa → pop pattern VC0,VC0,VC0,VC1 repeating; counters 3:1 after 4 pops.
- **Work-conserving switch:** VC0 empty, VC1 holds 5 words, weight_VC1=2 → VC1 popped 5 times with at most one idle cycle per turn boundary; grant_cnt_VC1=5.
- **Back-pressure:** Pausa_D1=1 for 4 cycles mid-stream → pop_VC0/pop_VC1 both 0 during those 4 cycles plus 1; resume keeps the held credit.
- **Single-entry MF:** MF with 1 entry, head_vc_MF=1, Almost_Empty_MF=1 → exactly one pop_MF pulse. With Pausa_VC1=1 → no pop_MF until Pausa_VC1 falls.
- **Counter wrap:** CNT_W=8 with 256 VC0 pops → grant_cnt_VC0 returns to 0. Asserting enable=0 mid-stream → pops 0 next cycle, counters frozen.
